// File: rtl/note_judge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : note_judge                                                      |
// | Purpose  : grades notes at the lane target as PERFECT/GOOD/MISS and keeps  |
// |            score, combo and max combo. Optional macro JUDGE_EMPTY_PRESS_EN |
// |            turns a press with no note into a MISS.                         |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module note_judge #(
  parameter int NOTE_SPEED  = 200,
  parameter int PERFECT_MS  = 60,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic        i_is_target,
  input  logic        i_btn,
  output logic        o_perfect,
  output logic        o_good,
  output logic        o_miss,
  output logic [15:0] o_score,
  output logic [7:0]  o_combo,
  output logic [7:0]  o_max_combo
);

  localparam int c_win_w = ($clog2(NOTE_SPEED) > 8) ? $clog2(NOTE_SPEED) : 8;
  localparam int c_db_w  = ($clog2(DEBOUNCE_MS + 1) > 1) ? $clog2(DEBOUNCE_MS + 1) : 1;
  localparam logic [c_win_w-1:0] c_win_last = c_win_w'(NOTE_SPEED - 1);
  localparam logic [c_db_w-1:0]  c_db_last  = c_db_w'(DEBOUNCE_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_JUDGED = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic               r_btn_s1;
  logic               r_btn_s2;
  logic               r_btn_acc;
  logic               r_btn_acc_d;
  logic [c_db_w-1:0]  r_db_cnt;
  logic [c_win_w-1:0] r_win;
  logic               r_perfect;
  logic               r_good;
  logic               r_miss;
  logic [15:0]        r_score;
  logic [7:0]         r_combo;
  logic [7:0]         r_max_combo;

  logic               w_press;
  logic               w_expire;
  logic               w_close;
  logic               w_hit_p;
  logic               w_hit_g;
  logic               w_miss;
  logic [16:0]        w_score_sum;
  logic [7:0]         w_combo_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1    <= 1'b0;
      r_btn_s2    <= 1'b0;
      r_btn_acc   <= 1'b0;
      r_btn_acc_d <= 1'b0;
      r_db_cnt    <= '0;
    end else begin
      r_btn_s1    <= i_btn;
      r_btn_s2    <= r_btn_s1;
      r_btn_acc_d <= r_btn_acc;
      if (r_btn_s2 == r_btn_acc) begin
        r_db_cnt <= '0;
      end else if (i_tick) begin
        if (r_db_cnt == c_db_last) begin
          r_btn_acc <= r_btn_s2;
          r_db_cnt  <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + c_db_w'(1);
        end
      end
    end
  end

  assign w_press  = r_btn_acc & ~r_btn_acc_d;
  assign w_expire = i_tick && (r_win == c_win_last);
  assign w_close  = w_expire || !i_is_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_win   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_IDLE) begin
        r_win <= '0;
      end else if (i_tick) begin
        r_win <= r_win + c_win_w'(1);
      end
    end
  end

  // A press in ARMED always wins over a same-cycle expiry or target fall.
  always_comb begin
    w_state_nx = r_state;
    w_hit_p    = 1'b0;
    w_hit_g    = 1'b0;
    w_miss     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_is_target) begin
          w_state_nx = S_ARMED;
        end
`ifdef JUDGE_EMPTY_PRESS_EN
        else if (w_press) begin
          w_miss = 1'b1;
        end
`endif
      end
      S_ARMED: begin
        if (w_press) begin
          if (int'(r_win) < PERFECT_MS) begin
            w_hit_p = 1'b1;
          end else begin
            w_hit_g = 1'b1;
          end
          w_state_nx = w_close ? S_IDLE : S_JUDGED;
        end else if (w_close) begin
          w_miss     = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      S_JUDGED: begin
        if (w_close) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_score_sum = {1'b0, r_score} + (w_hit_p ? 17'd2 : (w_hit_g ? 17'd1 : 17'd0));
  assign w_combo_inc = (r_combo == 8'hFF) ? 8'hFF : r_combo + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perfect   <= 1'b0;
      r_good      <= 1'b0;
      r_miss      <= 1'b0;
      r_score     <= '0;
      r_combo     <= '0;
      r_max_combo <= '0;
    end else begin
      r_perfect <= w_hit_p;
      r_good    <= w_hit_g;
      r_miss    <= w_miss;
      if (w_hit_p || w_hit_g) begin
        r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        r_combo <= w_combo_inc;
        if (w_combo_inc > r_max_combo) begin
          r_max_combo <= w_combo_inc;
        end
      end else if (w_miss) begin
        r_combo <= '0;
      end
    end
  end

  assign o_perfect   = r_perfect;
  assign o_good      = r_good;
  assign o_miss      = r_miss;
  assign o_score     = r_score;
  assign o_combo     = r_combo;
  assign o_max_combo = r_max_combo;

endmodule
`default_nettype wire

// File: tb/tb_note_judge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_note_judge                                                   |
// | Purpose  : self-checking bench for note_judge (table, directed, random).   |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_note_judge;

  localparam int NS   = 200;
  localparam int PM   = 60;
  localparam int DEB  = 10;
  localparam int TPER = 4;
`ifdef JUDGE_EMPTY_PRESS_EN
  localparam bit EMPTY_EN = 1'b1;
`else
  localparam bit EMPTY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_tick = 1'b0;
  logic        i_is_target = 1'b0;
  logic        i_btn = 1'b0;
  logic        o_perfect;
  logic        o_good;
  logic        o_miss;
  logic [15:0] o_score;
  logic [7:0]  o_combo;
  logic [7:0]  o_max_combo;

  note_judge #(.NOTE_SPEED(NS), .PERFECT_MS(PM), .DEBOUNCE_MS(DEB)) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_is_target(i_is_target), .i_btn(i_btn),
    .o_perfect(o_perfect), .o_good(o_good), .o_miss(o_miss),
    .o_score(o_score), .o_combo(o_combo), .o_max_combo(o_max_combo)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tcnt    = 0;
  int n_p, n_g, n_m;

  // Reference model state: button history, accepted level, window bookkeeping.
  bit m_s1, m_s2, m_acc, m_rose, m_open, m_hit, m_p, m_g, m_m;
  int m_cnt, m_win, m_score, m_combo, m_max;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_acc = 0; m_rose = 0; m_open = 0; m_hit = 0;
    m_p = 0; m_g = 0; m_m = 0; m_cnt = 0; m_win = 0;
    m_score = 0; m_combo = 0; m_max = 0;
  endtask

  task automatic model_step();
    bit press, expire, close;
    int add;
    if (rst) begin
      model_reset();
      return;
    end
    press = m_rose;
    m_rose = 0;
    if (m_s2 == m_acc) m_cnt = 0;
    else if (i_tick) begin
      m_cnt++;
      if (m_cnt == DEB) begin
        m_acc = m_s2;
        m_cnt = 0;
        m_rose = m_acc;
      end
    end
    m_s2 = m_s1;
    m_s1 = i_btn;
    m_p = 0; m_g = 0; m_m = 0;
    expire = m_open && i_tick && (m_win == NS - 1);
    close  = expire || !i_is_target;
    if (!m_open) begin
      if (i_is_target) begin
        m_open = 1; m_hit = 0; m_win = 0;
      end else if (press && EMPTY_EN) m_m = 1;
    end else begin
      if (!m_hit && press) begin
        if (m_win < PM) m_p = 1; else m_g = 1;
        m_hit = 1;
      end else if (!m_hit && close) m_m = 1;
      if (close) m_open = 0;
      else if (i_tick) m_win++;
    end
    if (m_p || m_g) begin
      add = m_p ? 2 : 1;
      m_score = (m_score + add > 65535) ? 65535 : m_score + add;
      m_combo = (m_combo == 255) ? 255 : m_combo + 1;
      if (m_combo > m_max) m_max = m_combo;
    end else if (m_m) m_combo = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    n_p += int'(o_perfect);
    n_g += int'(o_good);
    n_m += int'(o_miss);
    chk("model", {o_perfect, o_good, o_miss, o_score, o_combo, o_max_combo},
        {m_p, m_g, m_m, 16'(m_score), 8'(m_combo), 8'(m_max)});
    tcnt++;
    i_tick = (tcnt % TPER == 0);
  endtask

  task automatic ticks(input int n);
    int c = 0;
    while (c < n) begin
      cyc();
      if (i_tick) c++;
    end
  endtask

  task automatic btn_at(input int c, input int p, input bit bounce);
    if (p < 0) return;
    if (bounce && c >= p - DEB - 8 && c < p - DEB) i_btn = ((c - (p - DEB - 8)) % 2 == 0);
    else if (c == p - DEB) i_btn = 1'b1;
    else if (c == p + 20) i_btn = 1'b0;
  endtask

  // Lane-aligned note: target rises one clk after a tick, falls one clk after tick len.
  task automatic note(input int len, input int p0, input int p1, input int p2, input bit bounce);
    int c = 0;
    n_p = 0; n_g = 0; n_m = 0;
    do cyc(); while (!i_tick);
    cyc();
    i_is_target = 1'b1;
    btn_at(0, p0, bounce); btn_at(0, p1, 1'b0); btn_at(0, p2, 1'b0);
    while (c < len + 40) begin
      cyc();
      if (c == len) i_is_target = 1'b0;
      if (i_tick) begin
        c++;
        btn_at(c, p0, bounce); btn_at(c, p1, 1'b0); btn_at(c, p2, 1'b0);
      end
    end
    i_btn = 1'b0;
  endtask

  typedef struct {
    int p;
    int ep, eg, em;
    int score, combo, maxc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{20,  1, 0, 0, 2,  1, 1};
    tbl[1] = '{150, 0, 1, 0, 3,  2, 2};
    tbl[2] = '{-1,  0, 0, 1, 3,  0, 2};
    tbl[3] = '{59,  1, 0, 0, 5,  1, 2};
    tbl[4] = '{60,  0, 1, 0, 6,  2, 2};
    tbl[5] = '{199, 0, 1, 0, 7,  3, 3};
    tbl[6] = '{100, 0, 1, 0, 8,  4, 4};
    tbl[7] = '{10,  1, 0, 0, 10, 5, 5};

    model_reset();
    repeat (3) cyc();
    chk("rst_strobes", {o_perfect, o_good, o_miss}, 0);
    chk("rst_score", o_score, 0);
    chk("rst_combo", o_combo, 0);
    chk("rst_max", o_max_combo, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      note(NS, tbl[i].p, -1, -1, 1'b0);
      chk($sformatf("tbl%0d_perfect", i), n_p, tbl[i].ep);
      chk($sformatf("tbl%0d_good", i), n_g, tbl[i].eg);
      chk($sformatf("tbl%0d_miss", i), n_m, tbl[i].em);
      chk($sformatf("tbl%0d_score", i), o_score, tbl[i].score);
      chk($sformatf("tbl%0d_combo", i), o_combo, tbl[i].combo);
      chk($sformatf("tbl%0d_max", i), o_max_combo, tbl[i].maxc);
    end

    // Press with no note present.
    n_p = 0; n_g = 0; n_m = 0;
    i_btn = 1'b1; ticks(15);
    i_btn = 1'b0; ticks(15);
    chk("empty_miss", n_m, EMPTY_EN ? 1 : 0);
    chk("empty_hits", n_p + n_g, 0);
    chk("empty_combo", o_combo, EMPTY_EN ? 0 : 5);
    chk("empty_score", o_score, 10);

    // Two back-to-back notes; third press lands in JUDGED.
    note(2 * NS, 10, 210, 250, 1'b0);
    chk("adj_perfect", n_p, 2);
    chk("adj_other", n_g + n_m, 0);
    chk("adj_score", o_score, 14);
    chk("adj_combo", o_combo, EMPTY_EN ? 2 : 7);
    chk("adj_max", o_max_combo, EMPTY_EN ? 5 : 7);

    // Bouncing button: last toggle at window ms 50, so the press lands at ms 60.
    note(NS, 60, -1, -1, 1'b1);
    chk("bounce_good", n_g, 1);
    chk("bounce_other", n_p + n_m, 0);
    chk("bounce_score", o_score, 15);

    for (int k = 0; k < 16; k++) begin
      int len, q0, q1, q2;
      bit bn;
      len = $urandom_range(30, 420);
      q0 = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(18, len + 15);
      q1 = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(10, len + 15);
      q2 = ($urandom_range(0, 2) != 0) ? -1 : $urandom_range(10, len + 15);
      bn = (q0 >= 18) && ($urandom_range(0, 1) == 1);
      note(len, q0, q1, q2, bn);
    end

    // Saturation: preload near the top of score and combo.
    cyc();
    force dut.r_score = 16'hFFFE;
    force dut.r_combo = 8'hFF;
    #1;
    release dut.r_score;
    release dut.r_combo;
    m_score = 65534;
    m_combo = 255;
    note(NS, 20, -1, -1, 1'b0);
    chk("sat_perfect", n_p, 1);
    chk("sat_score", o_score, 16'hFFFF);
    chk("sat_combo", o_combo, 255);
    chk("sat_max", o_max_combo, 255);
    note(NS, 30, -1, -1, 1'b0);
    chk("sat_score2", o_score, 16'hFFFF);
    chk("sat_combo2", o_combo, 255);

    // Reset in the middle of an armed window.
    n_p = 0; n_g = 0; n_m = 0;
    do cyc(); while (!i_tick);
    cyc();
    i_is_target = 1'b1;
    ticks(50);
    rst = 1'b1;
    #1;
    chk("mid_rst_strobes", {o_perfect, o_good, o_miss}, 0);
    chk("mid_rst_score", o_score, 0);
    chk("mid_rst_combo", o_combo, 0);
    chk("mid_rst_max", o_max_combo, 0);
    model_reset();
    repeat (3) cyc();
    i_is_target = 1'b0;
    rst = 1'b0;
    ticks(NS + 20);
    chk("mid_rst_no_strobe", n_p + n_g + n_m, 0);
    chk("mid_rst_score_after", o_score, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
